// File: rtl/ib_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-buffer fetch scheduler.
// IB geometry constants are shared with the IB itself; the state encoding is
// fixed so that debug tooling can decode the state register directly.
package ib_fetch_ctrl_pkg;

    localparam int IB_DEPTH          = 16;
    localparam int IB_DEPTH_LOG2     = 4;
    localparam int FETCH_WIDTH       = 4;
    localparam int FETCH_BLOCK_BYTES = 16;
    localparam int MAX_INFLIGHT      = 2;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    // Start of the next aligned fetch block; wraps to 0 past the top of memory.
    function automatic logic [31:0] next_block_pc(input logic [31:0] pc);
        logic [31:0] block_mask;
        block_mask = ~(32'(FETCH_BLOCK_BYTES) - 32'd1);
        return (pc & block_mask) + 32'(FETCH_BLOCK_BYTES);
    endfunction

endpackage

// File: rtl/ib_fetch_ctrl_if.sv
// Fetch request/response bundle between the fetch scheduler (master), the
// I-cache request/response ports and the IB push port (slave side).
interface ib_fetch_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [3:0]  resp_mask;
    logic [2:0]  push_num;

    modport master (
        output req_valid,
        output req_pc,
        output push_num,
        input  req_ready,
        input  resp_valid,
        input  resp_mask
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  push_num,
        output req_ready,
        output resp_valid,
        output resp_mask
    );

endinterface

// File: rtl/ib_popcnt4.sv
// 4-bit population count: number of valid instruction slots in a fetch block.
// Also used by decode, so it stays a standalone module.
module ib_popcnt4 (
    input  logic [3:0] mask,
    output logic [2:0] count
);

    logic [2:0] bit_ext [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ext
            assign bit_ext[gi] = {2'b00, mask[gi]};
        end
    endgenerate

    // Adder tree over the zero-extended slot bits.
    always_comb begin
        count = (bit_ext[0] + bit_ext[1]) + (bit_ext[2] + bit_ext[3]);
    end

endmodule

// File: rtl/ib_fetch_ctrl.sv
// Fetch-side scheduler for the instruction buffer.
// Issues 16-byte fetch requests only when the IB has room for every
// outstanding block, converts responses into IB push counts, and after a
// flush discards stale in-flight responses before fetching from the new PC.
// Optional build macro: IB_FETCH_PERF_EN adds saturating performance counters
// perf_full_stall and perf_flush_cnt.
module ib_fetch_ctrl #(
    parameter int          IB_DEPTH      = ib_fetch_ctrl_pkg::IB_DEPTH,
    parameter int          IB_DEPTH_LOG2 = ib_fetch_ctrl_pkg::IB_DEPTH_LOG2,
    parameter int          FETCH_WIDTH   = ib_fetch_ctrl_pkg::FETCH_WIDTH,
    parameter int          MAX_INFLIGHT  = ib_fetch_ctrl_pkg::MAX_INFLIGHT,
    parameter logic [31:0] RESET_PC      = ib_fetch_ctrl_pkg::RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [31:0]              flush_pc,
    input  logic [IB_DEPTH_LOG2:0]   ib_size,
    ib_fetch_ctrl_if.master          bus,
    output logic                     busy_drain
`ifdef IB_FETCH_PERF_EN
    ,
    output logic [31:0]              perf_full_stall,
    output logic [31:0]              perf_flush_cnt
`endif
);

    import ib_fetch_ctrl_pkg::*;

    localparam int OUT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int OCC_W = IB_DEPTH_LOG2 + 3;

    fetch_state_e      state_reg, state_next;
    logic [31:0]       pc_reg, pc_next;
    logic [OUT_W-1:0]  outstanding_reg, outstanding_next;
    logic [OUT_W-1:0]  discard_reg, discard_next;
    logic [OUT_W-1:0]  pending;

    logic [OCC_W-1:0]  occ_eff;
    logic              credit_ok;
    logic              slot_ok;
    logic              req_valid_int;
    logic              accept;
    logic              retire;
    logic [2:0]        mask_count;

    ib_popcnt4 u_popcnt (
        .mask  (bus.resp_mask),
        .count (mask_count)
    );

    // Every outstanding fetch reserves a full block of IB slots; pops in the
    // current cycle are ignored so the check errs on the safe side.
    assign occ_eff   = OCC_W'(ib_size) + (OCC_W'(outstanding_reg) * OCC_W'(FETCH_WIDTH));
    assign credit_ok = (occ_eff + OCC_W'(FETCH_WIDTH)) <= OCC_W'(IB_DEPTH);
    assign slot_ok   = outstanding_reg < OUT_W'(MAX_INFLIGHT);

    assign req_valid_int = (state_reg == RUN) && !flush && !rst && slot_ok && credit_ok;
    assign accept        = req_valid_int && bus.req_ready;
    // A response with nothing outstanding is an environment error; do not underflow.
    assign retire        = bus.resp_valid && (outstanding_reg != '0);

    assign bus.req_valid = req_valid_int;
    assign bus.req_pc    = pc_reg;
    assign bus.push_num  = ((state_reg == RUN) && !flush && bus.resp_valid) ? mask_count : 3'd0;
    assign busy_drain    = (state_reg == DRAIN);

    // Responses still owed once this cycle's retire is taken into account.
    // No request can be accepted in a flush cycle, so only retire matters.
    assign pending = outstanding_reg - OUT_W'(retire);

    // Next-state logic: PC advance, credit tracking, flush redirect and drain.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + OUT_W'(accept) - OUT_W'(retire);
        discard_next     = discard_reg;

        if (accept) begin
            pc_next = next_block_pc(pc_reg);
        end

        if (flush) begin
            pc_next      = flush_pc;
            discard_next = pending;
            state_next   = (pending == '0) ? RUN : DRAIN;
        end else if ((state_reg == DRAIN) && retire) begin
            discard_next = discard_reg - OUT_W'(1);
            if (discard_reg == OUT_W'(1)) begin
                state_next = RUN;
            end
        end
    end

    // State register; reset dominates flush and any handshake in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

`ifdef IB_FETCH_PERF_EN
    logic [31:0] full_stall_reg;
    logic [31:0] flush_cnt_reg;
    logic        full_stall_hit;

    // Cycles where fetch could go except for lack of IB room.
    assign full_stall_hit = (state_reg == RUN) && !flush && slot_ok && !credit_ok;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_stall_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            if (full_stall_hit && (full_stall_reg != '1)) begin
                full_stall_reg <= full_stall_reg + 32'd1;
            end
            if (flush && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_full_stall = full_stall_reg;
    assign perf_flush_cnt  = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_ib_fetch_ctrl.sv
// Self-checking bench for ib_fetch_ctrl: credit and push-count tables plus
// hand-written flush/drain/reset sequences. Accepted request PCs and response
// push counts are checked against scoreboard queues filled when stimulus is driven.
module tb_ib_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic [4:0]  ib_size;
    logic        busy_drain;

    ib_fetch_ctrl_if fi ();

    ib_fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .ib_size    (ib_size),
        .bus        (fi),
        .busy_drain (busy_drain)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] pc_q[$];
    int          push_q[$];
    logic [31:0] exp_pc;

    typedef struct {
        logic [4:0] ib;
        int         n_acc;
        logic       exp_valid;
    } credit_vec_t;

    typedef struct {
        logic [3:0] mask;
        int         exp_push;
    } push_vec_t;

    credit_vec_t cv[8];
    push_vec_t   pv[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        flush         = 1'b0;
        flush_pc      = 32'h0;
        ib_size       = 5'd0;
        fi.req_ready  = 1'b0;
        fi.resp_valid = 1'b0;
        fi.resp_mask  = 4'b0;
        tick();
        rst    = 1'b0;
        exp_pc = RST_PC;
    endtask

    task automatic accept_n(input int n);
        fi.req_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            pc_q.push_back(exp_pc);
            exp_pc = (exp_pc & 32'hFFFF_FFF0) + 32'h10;
            tick();
        end
        fi.req_ready = 1'b0;
    endtask

    task automatic respond(input logic [3:0] mask, input int exp_push);
        fi.resp_valid = 1'b1;
        fi.resp_mask  = mask;
        push_q.push_back(exp_push);
        tick();
        fi.resp_valid = 1'b0;
        fi.resp_mask  = 4'b0;
    endtask

    // Scoreboard monitor and invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (fi.req_valid && fi.req_ready) begin
                if (pc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: got req_pc %0h expected no accept", fi.req_pc);
                end else begin
                    chk("req_pc", fi.req_pc, pc_q.pop_front());
                end
            end
            if (fi.resp_valid) begin
                if (push_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got push_num %0d expected no response", fi.push_num);
                end else begin
                    chk("push_num", 32'(fi.push_num), 32'(push_q.pop_front()));
                end
            end
            if (dut.outstanding_reg > 2'd2) begin
                errors++;
                $display("FAIL outstanding_bound: got %0d expected <= 2", dut.outstanding_reg);
            end
            if (int'(ib_size) + int'(fi.push_num) > 16) begin
                errors++;
                $display("FAIL ib_overflow: got %0d expected <= 16", int'(ib_size) + int'(fi.push_num));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cv[0] = '{5'd12, 0, 1'b1};
        cv[1] = '{5'd13, 0, 1'b0};
        cv[2] = '{5'd8,  1, 1'b1};
        cv[3] = '{5'd9,  1, 1'b0};
        cv[4] = '{5'd4,  2, 1'b0};
        cv[5] = '{5'd4,  1, 1'b1};
        cv[6] = '{5'd16, 0, 1'b0};
        cv[7] = '{5'd0,  0, 1'b1};

        pv[0] = '{4'b0111, 3};
        pv[1] = '{4'b0000, 0};
        pv[2] = '{4'b1111, 4};
        pv[3] = '{4'b0001, 1};
        pv[4] = '{4'b0011, 2};

        // Reset state and first requests.
        rst           = 1'b1;
        flush         = 1'b0;
        flush_pc      = 32'h0;
        ib_size       = 5'd0;
        fi.req_ready  = 1'b0;
        fi.resp_valid = 1'b0;
        fi.resp_mask  = 4'b0;
        @(negedge clk);
        chk("reset_req_valid", 32'(fi.req_valid), 32'd0);
        chk("reset_push_num", 32'(fi.push_num), 32'd0);
        chk("reset_busy_drain", 32'(busy_drain), 32'd0);
        tick();
        rst    = 1'b0;
        exp_pc = RST_PC;
        @(negedge clk);
        chk("first_req_valid", 32'(fi.req_valid), 32'd1);
        chk("first_req_pc", fi.req_pc, RST_PC);
        tick();
        accept_n(2);
        @(negedge clk);
        chk("outstanding_two", 32'(dut.outstanding_reg), 32'd2);
        chk("max_inflight_block", 32'(fi.req_valid), 32'd0);
        tick();

        // Credit check table.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            accept_n(cv[i].n_acc);
            ib_size = cv[i].ib;
            @(negedge clk);
            chk($sformatf("credit%0d_ib%0d_out%0d", i, cv[i].ib, cv[i].n_acc),
                32'(fi.req_valid), 32'(cv[i].exp_valid));
            tick();
        end

        // Push count table: each response retires its credit.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            accept_n(1);
            respond(pv[i].mask, pv[i].exp_push);
            @(negedge clk);
            chk($sformatf("retire%0d", i), 32'(dut.outstanding_reg), 32'd0);
            tick();
        end

        // Flush with two in flight: drain both, then redirect.
        do_reset();
        accept_n(2);
        flush    = 1'b1;
        flush_pc = 32'h1c000104;
        @(negedge clk);
        chk("flush_gates_req", 32'(fi.req_valid), 32'd0);
        tick();
        flush  = 1'b0;
        exp_pc = 32'h1c000104;
        @(negedge clk);
        chk("drain_entered", 32'(busy_drain), 32'd1);
        chk("drain_discard", 32'(dut.discard_reg), 32'd2);
        chk("drain_no_req", 32'(fi.req_valid), 32'd0);
        tick();
        respond(4'b1111, 0);
        @(negedge clk);
        chk("drain_still", 32'(busy_drain), 32'd1);
        tick();
        respond(4'b0011, 0);
        @(negedge clk);
        chk("drain_exit", 32'(busy_drain), 32'd0);
        chk("drain_outstanding", 32'(dut.outstanding_reg), 32'd0);
        tick();
        accept_n(2);

        // Flush coinciding with the only outstanding response.
        do_reset();
        accept_n(1);
        flush         = 1'b1;
        flush_pc      = 32'h1c000200;
        fi.resp_valid = 1'b1;
        fi.resp_mask  = 4'b1111;
        push_q.push_back(0);
        tick();
        flush         = 1'b0;
        fi.resp_valid = 1'b0;
        fi.resp_mask  = 4'b0;
        @(negedge clk);
        chk("flush_resp_run", 32'(busy_drain), 32'd0);
        chk("flush_resp_valid", 32'(fi.req_valid), 32'd1);
        chk("flush_resp_pc", fi.req_pc, 32'h1c000200);
        chk("flush_resp_outstanding", 32'(dut.outstanding_reg), 32'd0);
        tick();

        // Redirect near the top of memory: PC wraps to 0.
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFF0;
        tick();
        flush  = 1'b0;
        exp_pc = 32'hFFFF_FFF0;
        @(negedge clk);
        chk("wrap_no_drain", 32'(busy_drain), 32'd0);
        tick();
        accept_n(2);

        // Flush during DRAIN, then reset mid-DRAIN.
        do_reset();
        accept_n(2);
        flush    = 1'b1;
        flush_pc = 32'h1c000300;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("rst_pre_drain", 32'(busy_drain), 32'd1);
        tick();
        flush         = 1'b1;
        flush_pc      = 32'h1c000400;
        fi.resp_valid = 1'b1;
        fi.resp_mask  = 4'b0111;
        push_q.push_back(0);
        tick();
        flush         = 1'b0;
        fi.resp_valid = 1'b0;
        fi.resp_mask  = 4'b0;
        @(negedge clk);
        chk("reflush_drain", 32'(busy_drain), 32'd1);
        chk("reflush_discard", 32'(dut.discard_reg), 32'd1);
        chk("reflush_pc", fi.req_pc, 32'h1c000400);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_gates_req", 32'(fi.req_valid), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy_drain", 32'(busy_drain), 32'd0);
        chk("rst_outstanding", 32'(dut.outstanding_reg), 32'd0);
        chk("rst_discard", 32'(dut.discard_reg), 32'd0);
        chk("rst_req_valid", 32'(fi.req_valid), 32'd1);
        chk("rst_req_pc", fi.req_pc, RST_PC);
        tick();

        chk("pc_q_empty", 32'(pc_q.size()), 32'd0);
        chk("push_q_empty", 32'(push_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
